// File: rtl/j17_control_unit.sv
// Fetch/decode sequencer for the J17 core: drives the datapath control bundle and a one-cycle commit strobe.
// 3 cycles per plain instruction, 4 with a RAM/stack/indirect operand; FETCH waits indefinitely for instr_valid.
module j17_control_unit #(
  parameter int          IMEM_AW  = 10,
  parameter logic [4:0]  HALT_OPC = 5'd24
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               run,
  input  logic [31:0]        pc,
  output logic               instr_req,
  output logic [IMEM_AW-1:0] instr_addr,
  input  logic               instr_valid,
  input  logic [31:0]        instr,
  output logic               step,
  output logic [4:0]         alucode,
  output logic [2:0]         op1,
  output logic [20:0]        op2,
  output logic               imControl,
  output logic               flag,
  output logic               flag1,
  output logic [2:0]         pcControl,
  output logic               writecode,
  output logic               regenable,
  output logic [1:0]         ramenable,
  output logic [1:0]         stackSelect,
  output logic               halted,
  output logic               illegal
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMWAIT, S_EXEC, S_HALT
  } state_t;

  state_t      state, next_state;
  logic [31:0] ir_q;
  logic        legal_q;

  logic [4:0]  opc;
  logic [4:0]  d_alu;
  logic [2:0]  d_pcc;
  logic        d_wc, d_reg, d_legal, d_ill;
  logic [1:0]  d_ram, d_stk;

  logic        unused_pc;
  assign unused_pc  = ^pc[31:IMEM_AW];
  assign instr_addr = pc[IMEM_AW-1:0];

  // Operand fields come straight from the instruction register; mode bits are masked for NOP-decoded words.
  assign op1       = ir_q[26:24];
  assign op2       = ir_q[20:0];
  assign imControl = ir_q[23] & legal_q;
  assign flag      = ir_q[22] & legal_q;
  assign flag1     = ir_q[21] & legal_q;

  assign opc = instr[31:27];

  always_comb begin
    d_alu   = 5'd0;
    d_pcc   = 3'd0;
    d_wc    = 1'b0;
    d_reg   = 1'b0;
    d_ram   = 2'b00;
    d_stk   = 2'b00;
    d_legal = (opc <= 5'd23) && (opc != HALT_OPC);
    d_ill   = (opc > 5'd23) && (opc != HALT_OPC);
    if (opc <= 5'd11) begin
      d_alu = opc;
      d_reg = 1'b1;
    end else begin
      case (opc) inside
        5'd12:          begin d_wc = 1'b1; d_reg = 1'b1; end
        [5'd13:5'd19]:  d_pcc = 3'(opc - 5'd12);
        5'd20:          begin d_ram = 2'b01; d_reg = 1'b1; end
        5'd21:          d_ram = 2'b10;
        5'd22:          d_stk = 2'b01;
        5'd23:          begin d_stk = 2'b10; d_reg = 1'b1; end
        default:        ;
      endcase
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (run) next_state = S_FETCH;
      S_FETCH:   if (instr_valid) next_state = S_DECODE;
      S_DECODE: begin
        if (ir_q[31:27] == HALT_OPC)
          next_state = S_HALT;
        else if ((ramenable != 2'b00) || flag || flag1 || (stackSelect != 2'b00))
          next_state = S_MEMWAIT;
        else
          next_state = S_EXEC;
      end
      S_MEMWAIT: next_state = S_EXEC;
      // run is only honoured here, so an in-flight instruction always commits
      S_EXEC:    next_state = run ? S_FETCH : S_IDLE;
      S_HALT:    next_state = S_HALT;
      default:   next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      instr_req   <= 1'b0;
      step        <= 1'b0;
      halted      <= 1'b0;
      illegal     <= 1'b0;
      ir_q        <= 32'd0;
      legal_q     <= 1'b0;
      alucode     <= 5'd0;
      pcControl   <= 3'd0;
      writecode   <= 1'b0;
      regenable   <= 1'b0;
      ramenable   <= 2'b00;
      stackSelect <= 2'b00;
    end else begin
      state     <= next_state;
      instr_req <= (next_state == S_FETCH);
      step      <= (next_state == S_EXEC);
      halted    <= (next_state == S_HALT);
      if (state == S_FETCH && instr_valid) begin
        ir_q        <= instr;
        legal_q     <= d_legal;
        alucode     <= d_alu;
        pcControl   <= d_pcc;
        writecode   <= d_wc;
        regenable   <= d_reg;
        ramenable   <= d_ram;
        stackSelect <= d_stk;
        if (d_ill) illegal <= 1'b1;
      end else if (next_state == S_IDLE) begin
        ir_q        <= 32'd0;
        legal_q     <= 1'b0;
        alucode     <= 5'd0;
        pcControl   <= 3'd0;
        writecode   <= 1'b0;
        regenable   <= 1'b0;
        ramenable   <= 2'b00;
        stackSelect <= 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_j17_control_unit.sv
// Bench for j17_control_unit: hand-written vector table, randomized instructions against a rule-based model,
// and directed sequences for reset during EXEC, run release, and HALT.
module tb_j17_control_unit;

  logic        clock = 1'b0;
  logic        reset_n, run, instr_valid;
  logic [31:0] pc, instr;
  logic        instr_req, step, imControl, flag, flag1, writecode, regenable, halted, illegal;
  logic [9:0]  instr_addr;
  logic [4:0]  alucode;
  logic [2:0]  op1, pcControl;
  logic [20:0] op2;
  logic [1:0]  ramenable, stackSelect;

  int n_asrt = 0;
  int n_fail = 0;

  j17_control_unit #(.IMEM_AW(10), .HALT_OPC(5'd24)) dut (
    .clock(clock), .reset_n(reset_n), .run(run), .pc(pc),
    .instr_req(instr_req), .instr_addr(instr_addr),
    .instr_valid(instr_valid), .instr(instr), .step(step),
    .alucode(alucode), .op1(op1), .op2(op2), .imControl(imControl),
    .flag(flag), .flag1(flag1), .pcControl(pcControl), .writecode(writecode),
    .regenable(regenable), .ramenable(ramenable), .stackSelect(stackSelect),
    .halted(halted), .illegal(illegal)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  alu;
    logic [2:0]  pcc;
    logic        wc, rg;
    logic [1:0]  ram, stk;
    logic        imm, fl, fl1;
    logic [2:0]  o1;
    logic [20:0] o2;
    bit          mem;
  } exp_t;

  typedef struct {
    logic [31:0] w;
    int          dly;
    logic [4:0]  alu;
    logic [2:0]  pcc;
    logic        wc, rg;
    logic [1:0]  ram, stk;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t tv[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_asrt++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Behaviour of one instruction word, stated opcode range by opcode range.
  function automatic exp_t model(input logic [31:0] w);
    exp_t e;
    int   opc;
    bit   legal;
    opc   = int'(w[31:27]);
    legal = (opc <= 23);
    e.alu = (opc <= 11) ? w[31:27] : 5'd0;
    e.pcc = (opc >= 13 && opc <= 19) ? 3'(opc - 12) : 3'd0;
    e.wc  = (opc == 12);
    e.rg  = (opc <= 12) || (opc == 20) || (opc == 23);
    e.ram = (opc == 20) ? 2'b01 : (opc == 21) ? 2'b10 : 2'b00;
    e.stk = (opc == 22) ? 2'b01 : (opc == 23) ? 2'b10 : 2'b00;
    e.imm = legal & w[23];
    e.fl  = legal & w[22];
    e.fl1 = legal & w[21];
    e.o1  = w[26:24];
    e.o2  = w[20:0];
    e.mem = (e.ram != 2'b00) || (e.stk != 2'b00) || e.fl || e.fl1;
    return e;
  endfunction

  // Serves one fetch with dly idle cycles, then waits for step. lat counts cycles from the first FETCH cycle.
  task automatic fetch_and_wait(input logic [31:0] w, input int dly, input bit drop_run,
                                output int lat, output int reqs);
    int cyc;
    lat  = -1;
    reqs = 0;
    for (int i = 0; i < 20 && instr_req !== 1'b1; i++) tick();
    chk("fetch_req_seen", 64'(instr_req), 64'(1));
    if (instr_req !== 1'b1) return;
    pc = $urandom;
    #1;
    chk("instr_addr", 64'(instr_addr), 64'(pc[9:0]));
    for (int i = 0; i < dly; i++) begin
      reqs += int'(instr_req);
      pc = $urandom;
      tick();
    end
    reqs += int'(instr_req);
    instr = w;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    instr = $urandom;
    if (drop_run) run = 1'b0;
    cyc = dly + 1;
    while (cyc < dly + 8) begin
      if (step === 1'b1) begin
        lat = cyc;
        break;
      end
      reqs += int'(instr_req);
      tick();
      cyc++;
    end
  endtask

  task automatic chk_fields(input exp_t e);
    chk("alucode",     64'(alucode),     64'(e.alu));
    chk("pcControl",   64'(pcControl),   64'(e.pcc));
    chk("writecode",   64'(writecode),   64'(e.wc));
    chk("regenable",   64'(regenable),   64'(e.rg));
    chk("ramenable",   64'(ramenable),   64'(e.ram));
    chk("stackSelect", 64'(stackSelect), 64'(e.stk));
    chk("imControl",   64'(imControl),   64'(e.imm));
    chk("flag",        64'(flag),        64'(e.fl));
    chk("flag1",       64'(flag1),       64'(e.fl1));
    chk("op1",         64'(op1),         64'(e.o1));
    chk("op2",         64'(op2),         64'(e.o2));
  endtask

  initial begin
    int          lat, reqs, hreq, hstep;
    bit          ill_exp;
    exp_t        e;
    logic [31:0] w;
    logic [4:0]  ropc;

    //        word                                       dly alu   pcc  wc rg ram    stk    ill lat
    tv[0] = '{{5'd1,  3'd2, 1'b1, 2'b00, 21'd5},         0, 5'd1,  3'd0, 0, 1, 2'b00, 2'b00, 0, 2};
    tv[1] = '{{5'd20, 3'd3, 1'b0, 2'b01, 21'd100},       0, 5'd0,  3'd0, 0, 1, 2'b01, 2'b00, 0, 3};
    tv[2] = '{{5'd19, 3'd0, 1'b1, 2'b00, 21'd64},        0, 5'd0,  3'd7, 0, 0, 2'b00, 2'b00, 0, 2};
    tv[3] = '{{5'd12, 3'd5, 1'b1, 2'b00, 21'd7},         0, 5'd0,  3'd0, 1, 1, 2'b00, 2'b00, 0, 2};
    tv[4] = '{{5'd11, 3'd7, 1'b0, 2'b00, 21'h1FFFFF},    5, 5'd11, 3'd0, 0, 1, 2'b00, 2'b00, 0, 7};
    tv[5] = '{{5'd21, 3'd1, 1'b0, 2'b00, 21'd9},         0, 5'd0,  3'd0, 0, 0, 2'b10, 2'b00, 0, 3};
    tv[6] = '{{5'd22, 3'd4, 1'b0, 2'b00, 21'd0},         1, 5'd0,  3'd0, 0, 0, 2'b00, 2'b01, 0, 4};
    tv[7] = '{{5'd27, 3'd4, 1'b1, 2'b11, 21'd3},         0, 5'd0,  3'd0, 0, 0, 2'b00, 2'b00, 1, 2};
    tv[8] = '{{5'd23, 3'd6, 1'b0, 2'b00, 21'd0},         0, 5'd0,  3'd0, 0, 1, 2'b00, 2'b10, 1, 3};
    tv[9] = '{{5'd13, 3'd1, 1'b0, 2'b10, 21'd2},         2, 5'd0,  3'd1, 0, 0, 2'b00, 2'b00, 1, 5};

    reset_n = 1'b0; run = 1'b0; instr_valid = 1'b0; instr = '0; pc = '0;
    #12;
    chk("rst_instr_req", 64'(instr_req), 64'(0));
    chk("rst_step",      64'(step),      64'(0));
    chk("rst_halted",    64'(halted),    64'(0));
    chk("rst_illegal",   64'(illegal),   64'(0));
    chk("rst_regenable", 64'(regenable), 64'(0));
    chk("rst_op2",       64'(op2),       64'(0));
    tick();
    reset_n = 1'b1;
    tick(); tick();
    chk("idle_no_req", 64'(instr_req), 64'(0));
    run = 1'b1;

    // Hand-written vectors
    for (int i = 0; i < 10; i++) begin
      fetch_and_wait(tv[i].w, tv[i].dly, 1'b0, lat, reqs);
      chk($sformatf("tv%0d_latency", i),  64'(lat),         64'(tv[i].lat));
      chk($sformatf("tv%0d_reqs", i),     64'(reqs),        64'(tv[i].dly + 1));
      chk($sformatf("tv%0d_alu", i),      64'(alucode),     64'(tv[i].alu));
      chk($sformatf("tv%0d_pcc", i),      64'(pcControl),   64'(tv[i].pcc));
      chk($sformatf("tv%0d_wc", i),       64'(writecode),   64'(tv[i].wc));
      chk($sformatf("tv%0d_reg", i),      64'(regenable),   64'(tv[i].rg));
      chk($sformatf("tv%0d_ram", i),      64'(ramenable),   64'(tv[i].ram));
      chk($sformatf("tv%0d_stk", i),      64'(stackSelect), 64'(tv[i].stk));
      chk($sformatf("tv%0d_illegal", i),  64'(illegal),     64'(tv[i].ill));
      chk_fields(model(tv[i].w));
      tick();
      chk($sformatf("tv%0d_step_once", i), 64'(step), 64'(0));
    end

    // Randomized instructions against the model; illegal is already sticky from tv[7]
    ill_exp = 1'b1;
    for (int n = 0; n < 40; n++) begin
      ropc = 5'($urandom_range(0, 31));
      if (ropc == 5'd24) ropc = 5'd0;
      w = {ropc, 27'($urandom)};
      e = model(w);
      if (ropc >= 5'd25) ill_exp = 1'b1;
      begin
        int d;
        d = $urandom_range(0, 3);
        fetch_and_wait(w, d, 1'b0, lat, reqs);
        chk("rnd_latency", 64'(lat),  64'(d + (e.mem ? 3 : 2)));
        chk("rnd_reqs",    64'(reqs), 64'(d + 1));
      end
      chk_fields(e);
      chk("rnd_illegal", 64'(illegal), 64'(ill_exp));
      tick();
      chk("rnd_step_once", 64'(step), 64'(0));
    end

    // Asynchronous reset in the middle of the step cycle
    fetch_and_wait({5'd1, 3'd2, 1'b1, 2'b00, 21'd5}, 0, 1'b0, lat, reqs);
    chk("rstx_step_seen", 64'(step), 64'(1));
    #2;
    reset_n = 1'b0;
    #1;
    chk("rstx_step",      64'(step),      64'(0));
    chk("rstx_regenable", 64'(regenable), 64'(0));
    chk("rstx_instr_req", 64'(instr_req), 64'(0));
    chk("rstx_illegal",   64'(illegal),   64'(0));
    run = 1'b0;
    tick();
    reset_n = 1'b1;
    hreq = 0;
    for (int i = 0; i < 3; i++) begin tick(); hreq += int'(instr_req); end
    chk("rstx_idle", 64'(hreq), 64'(0));
    run = 1'b1;

    // run dropped during DECODE: the instruction still commits, then the sequencer parks
    fetch_and_wait({5'd3, 3'd1, 1'b0, 2'b00, 21'd9}, 0, 1'b1, lat, reqs);
    chk("drop_latency", 64'(lat), 64'(2));
    hreq = 0;
    for (int i = 0; i < 10; i++) begin tick(); hreq += int'(instr_req) + int'(step); end
    chk("drop_parked", 64'(hreq), 64'(0));
    run = 1'b1;
    for (int i = 0; i < 5 && instr_req !== 1'b1; i++) tick();
    chk("drop_resume", 64'(instr_req), 64'(1));

    // HALT: no step, no further fetches until reset
    pc = $urandom;
    instr = {5'd24, 27'd0};
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    chk("halt_halted", 64'(halted), 64'(1));
    chk("halt_step",   64'(step),   64'(0));
    hreq = 0; hstep = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      hreq  += int'(instr_req);
      hstep += int'(step) + int'(!halted);
    end
    chk("halt_no_req",  64'(hreq),  64'(0));
    chk("halt_held",    64'(hstep), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
